// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Build option: UART_ARB_LOCK_EN (packet lock) is consumed by uart_tx_arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} arb_state_e;

  localparam int UART_DW = 8;

  // Circular increment of an index in 0..n-1.
  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signals of the transmit arbiter.
// master: the arbiter itself; slave: requesters plus uart seen from outside.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 8
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               uart_tx_valid;
  logic [DW-1:0]      uart_tx_data;
  logic               uart_tx_busy;
  logic [GW-1:0]      grant_id;
  logic               active;

  modport master (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, uart_tx_valid, uart_tx_data, grant_id, active
  );

  modport slave (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, uart_tx_valid, uart_tx_data, grant_id, active
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of valid_i at or after
// ptr_i, wrapping circularly. Usable for any shared resource.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int pos;
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      if (valid_i[pos]) begin
        found_o = 1'b1;
        idx_o   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Each byte: IDLE grant -> ISSUE pulse -> WAIT_HI (busy rise or timeout)
// -> WAIT_LO (busy fall). Define UART_ARB_LOCK_EN to hold the grant on one
// requester until a byte flagged req_last completes.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int DW           = UART_DW,
  parameter int BUSY_TIMEOUT = 4
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e      state_q, state_d;
  logic [GW-1:0]   gid_q, gid_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] pick_valid;
  logic [GW-1:0]   pick_idx;
  logic            pick_found;
  logic [GW-1:0]   ptr_after;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic last_q, last_d;

  // While a packet is open only its owner is eligible.
  always_comb begin
    pick_valid = bus.req_valid;
    if (lock_q) pick_valid = bus.req_valid & (NREQ'(1) << gid_q);
  end
`else
  logic unused_last;
  assign unused_last = ^bus.req_last;

  // Plain per-byte arbitration: every valid requester competes.
  always_comb pick_valid = bus.req_valid;
`endif

  rr_pick #(.N(NREQ), .IW(GW)) u_pick (
    .valid_i (pick_valid),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign ptr_after = GW'(wrap_inc(int'(gid_q), NREQ));

  // Next-state logic for the byte sequencer.
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef UART_ARB_LOCK_EN
    lock_d  = lock_q;
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (!bus.uart_tx_busy && pick_found) begin
          gid_d   = pick_idx;
          data_d  = bus.req_data[int'(pick_idx)*DW +: DW];
`ifdef UART_ARB_LOCK_EN
          last_d  = bus.req_last[pick_idx];
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        // A uart that finishes before we notice busy is covered by the timeout.
        if (bus.uart_tx_busy || cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          state_d = WAIT_LO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LO: begin
        if (!bus.uart_tx_busy) begin
          state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
          if (last_q) begin
            lock_d = 1'b0;
            ptr_d  = ptr_after;
          end else begin
            lock_d = 1'b1;
          end
`else
          ptr_d = ptr_after;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef UART_ARB_LOCK_EN
      lock_q  <= lock_d;
      last_q  <= last_d;
`endif
    end
  end

  assign bus.uart_tx_valid = (state_q == ISSUE);
  assign bus.uart_tx_data  = data_q;
  assign bus.grant_id      = gid_q;
  assign bus.active        = (state_q != IDLE);

  // Accept pulse goes only to the granted requester, in the ISSUE cycle.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign bus.req_ready[gi] = (state_q == ISSUE) && (gid_q == GW'(gi));
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a serial uart model (18 clk/bit).
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 8;
  localparam int BT   = 4;
  localparam int BAUD = 18;
  localparam int GW   = $clog2(NREQ);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [GW-1:0] gid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .BUSY_TIMEOUT(BT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_count = 0;
  int tx_times[$];
  exp_t tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  logic line = 1'b1;
  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  logic stub_mode = 1'b0;
  assign bus.uart_tx_busy = model_busy | force_busy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  // Requesters: each serves its queue of {last,data}; pops on an accept pulse.
  initial begin
    logic [NREQ-1:0] rdy;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      if (rdy[0] && q0.size() > 0) void'(q0.pop_front());
      if (rdy[1] && q1.size() > 0) void'(q1.pop_front());
      bus.req_valid[0]   = (q0.size() > 0);
      bus.req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      bus.req_last[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
      bus.req_valid[1]   = (q1.size() > 0);
      bus.req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      bus.req_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
    end
  end

  // Uart model: busy one cycle after the pulse, 10-bit frame, then idle.
  initial begin
    logic [9:0] frame;
    forever begin
      @(negedge clk);
      if (bus.uart_tx_valid && !stub_mode) begin
        frame = {1'b1, bus.uart_tx_data, 1'b0};
        @(posedge clk);
        #1 model_busy = 1'b1;
        for (int b = 0; b < 10; b++) begin
          line = frame[b];
          repeat (BAUD) @(posedge clk);
          #1;
        end
        line = 1'b1;
        model_busy = 1'b0;
      end
    end
  end

  // Uart receive side: samples mid-bit and checks against rx_exp.
  initial begin
    logic [7:0] r;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (line === 1'b0) begin
        repeat (BAUD / 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (BAUD) @(negedge clk);
          r[b] = line;
        end
        repeat (BAUD) @(negedge clk);
        checks++;
        if (rx_exp.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected got=%02h expected=none", r);
        end else begin
          e = rx_exp.pop_front();
          if (r !== e) begin
            errors++;
            $display("FAIL rx_byte got=%02h expected=%02h", r, e);
          end else $display("rx   byte=%02h", r);
        end
      end
    end
  end

  // Transaction monitor: every uart pulse is matched to the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.uart_tx_valid) begin
        tx_count++;
        tx_times.push_back(cyc);
        checks++;
        if (tx_exp.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected got data=%02h gid=%0d expected=none", bus.uart_tx_data, bus.grant_id);
        end else begin
          e = tx_exp.pop_front();
          if (bus.uart_tx_data !== e.data || bus.grant_id !== e.gid ||
              bus.req_ready !== (NREQ'(1) << e.gid)) begin
            errors++;
            $display("FAIL tx_byte got data=%02h gid=%0d ready=%b expected data=%02h gid=%0d",
                     bus.uart_tx_data, bus.grant_id, bus.req_ready, e.data, e.gid);
          end else $display("tx   data=%02h gid=%0d ready=%b", bus.uart_tx_data, bus.grant_id, bus.req_ready);
        end
      end else if (bus.req_ready !== '0) begin
        checks++;
        errors++;
        $display("FAIL ready_without_valid got=%b expected=0", bus.req_ready);
      end
    end
  end

  task automatic push_tx(input logic [7:0] d, input int g, input bit on_wire);
    exp_t e;
    e.data = d;
    e.gid  = GW'(g);
    tx_exp.push_back(e);
    if (on_wire) rx_exp.push_back(d);
  endtask

  task automatic do_reset();
    int n;
    n = 0;
    while (model_busy && n < 1000) begin
      @(posedge clk);
      n++;
    end
    q0.delete();
    q1.delete();
    force_busy = 1'b0;
    stub_mode  = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_active", 32'(bus.active), 0);
    check("reset_tx_valid", 32'(bus.uart_tx_valid), 0);
    check("reset_outputs", {bus.req_ready, bus.grant_id, bus.uart_tx_data}, 0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || bus.active || bus.uart_tx_busy ||
            tx_exp.size() > 0 || rx_exp.size() > 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(n < 4000), 1);
  endtask

  initial begin
    int n0;
    int base;
    int n;

    // 1: single requester
    do_reset();
    q0.push_back({1'b1, 8'h41});
    push_tx(8'h41, 0, 1);
    drain("t1");

    // 2: two requesters, three bytes each, alternate on the wire
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back({1'b1, 8'h10});
      q1.push_back({1'b1, 8'h20});
      push_tx(8'h10, 0, 1);
      push_tx(8'h20, 1, 1);
    end
    drain("t2");

    // 3: busy held in IDLE blocks the grant
    do_reset();
    force_busy = 1'b1;
    q0.push_back({1'b1, 8'h55});
    push_tx(8'h55, 0, 1);
    n0 = tx_count;
    repeat (20) @(negedge clk);
    check("t3_held_no_tx", 32'(tx_count - n0), 0);
    check("t3_held_idle", 32'(bus.active), 0);
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_released_tx", 32'(tx_count - n0), 1);
    drain("t3");

    // 4: uart never raises busy; timeout paces bytes 7 cycles apart
    do_reset();
    stub_mode = 1'b1;
    base = tx_times.size();
    q0.push_back({1'b1, 8'hA1});
    q0.push_back({1'b1, 8'hA2});
    push_tx(8'hA1, 0, 0);
    push_tx(8'hA2, 0, 0);
    drain("t4");
    if (tx_times.size() >= base + 2)
      check("t4_gap", 32'(tx_times[base+1] - tx_times[base]), 7);
    else
      check("t4_two_pulses", 32'(tx_times.size() - base), 2);

    // 5: reset while in WAIT_LO
    do_reset();
    q1.push_back({1'b1, 8'h77});
    push_tx(8'h77, 1, 1);
    n = 0;
    while (!model_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_busy_seen", 32'(n < 200), 1);
    @(negedge clk);
    check("t5_active_before", 32'(bus.active), 1);
    check("t5_gid_before", 32'(bus.grant_id), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_active_after", 32'(bus.active), 0);
    check("t5_outputs_after", {bus.uart_tx_valid, bus.req_ready, bus.grant_id, bus.uart_tx_data}, 0);
    drain("t5");

    // 6: packet lock vs per-byte interleave
    do_reset();
    q0.push_back({1'b0, 8'h01});
    q0.push_back({1'b0, 8'h02});
    q0.push_back({1'b1, 8'h03});
    q1.push_back({1'b1, 8'h11});
    q1.push_back({1'b1, 8'h12});
`ifdef UART_ARB_LOCK_EN
    push_tx(8'h01, 0, 1);
    push_tx(8'h02, 0, 1);
    push_tx(8'h03, 0, 1);
    push_tx(8'h11, 1, 1);
    push_tx(8'h12, 1, 1);
`else
    push_tx(8'h01, 0, 1);
    push_tx(8'h11, 1, 1);
    push_tx(8'h02, 0, 1);
    push_tx(8'h12, 1, 1);
    push_tx(8'h03, 0, 1);
`endif
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
